// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte queue and frame pacer that sits directly in front of uart_tx.
//   Bytes can be pushed at any rate. They are drained one at a time onto the
//   uart_tx data/tx_start pair. uart_tx has no busy indication, so a local
//   timer holds off the next strobe until a full frame has left the line.
//
// Parameters
//   CLK_FREQ  clock frequency in Hz (must match the uart_tx instance)
//   UART_BPS  baud rate (must match the uart_tx instance)
//   DEPTH     FIFO entries, power of two, >= 2
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   wr_en     push wr_data this cycle (ignored while full)
//   wr_data   byte to queue
//   full      count == DEPTH
//   empty     count == 0
//   count     bytes currently queued (0..DEPTH)
//   overflow  sticky flag, set by a push attempt while full
//   tx_start  one-cycle strobe to uart_tx
//   tx_data   byte to uart_tx; valid with tx_start and held afterwards
//   busy      a frame is being paced or bytes are still queued
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter  int CLK_FREQ = 50000000,
  parameter  int UART_BPS = 9600,
  parameter  int DEPTH    = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          busy
);

  localparam int PERIOD       = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = 10 * PERIOD;
  localparam int TW           = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // full is derived from the registered count, so a push is refused while
  // full even when a pop frees a slot on the same edge.
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE) || !empty;

  assign push = wr_en && !full;
  // A byte pushed into an empty FIFO only becomes poppable on the next edge,
  // because empty is registered state as well.
  assign pop  = (state == S_IDLE) && !empty;

  // ---- storage: data only, no reset needed ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---- pointers, occupancy and overflow flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is implicit.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // ---- pacing FSM with registered strobe and data ----
  // From the pop edge the FSM stays in S_WAIT for FRAME_CYCLES edges, and
  // the next pop happens one edge later, so strobes are FRAME_CYCLES+1 apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            timer    <= '0;
            state    <= S_WAIT;
          end else begin
            tx_start <= 1'b0;
          end
        end
        S_WAIT: begin
          tx_start <= 1'b0;
          timer    <= timer + TW'(1);
          if (timer == TW'(FRAME_CYCLES - 1)) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with a scoreboard: accepted pushes queue
//   their expected byte; a monitor pops and compares on every tx_start.
//   A small serializer stands in for the downstream uart_tx so the line can
//   be sampled at mid-bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int PERIOD   = 10;
  localparam int FRAME    = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         pulse_t[$];
  logic       prev_start = 1'b0;
  logic [7:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      pulse_t.push_back(cyc);
      if (prev_start) begin
        total++;
        $display("FAIL tx_start_width: high on consecutive cycles (cycle %0d)", cyc);
      end
      if (sb.size() == 0) begin
        total++;
        $display("FAIL tx_unexpected: strobe with data %0h, expected none", tx_data);
      end else begin
        mon_exp = sb.pop_front();
        check("tx_data", int'(tx_data), int'(mon_exp));
      end
    end
    prev_start <= tx_start;
  end

  // ---- stand-in for uart_tx: start bit, 8 data bits LSB first, stop bit ----
  logic [9:0] frame;
  int         ucyc;
  int         ubit;
  logic       uact;
  logic       line;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uact  <= 1'b0;
      ucyc  <= 0;
      ubit  <= 0;
      frame <= '1;
    end else if (!uact) begin
      if (tx_start) begin
        uact  <= 1'b1;
        frame <= {1'b1, tx_data, 1'b0};
        ucyc  <= 0;
        ubit  <= 0;
      end
    end else if (ucyc == PERIOD - 1) begin
      ucyc <= 0;
      if (ubit == 9) uact <= 1'b0;
      else ubit <= ubit + 1;
    end else begin
      ucyc <= ucyc + 1;
    end
  end

  assign line = uact ? frame[ubit] : 1'b1;

  // ---- helpers ----
  task automatic push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, limit);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int bcnt;
  int cbefore;
  int seen;
  int n;
  int exp_bits[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  initial begin
    // 1. reset state
    repeat (3) @(negedge clk);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_count", int'(count), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2. single byte
    push(8'hA5, 1'b1);
    wr_en = 1'b0;
    check("t2_start_early", int'(tx_start), 0);
    check("t2_count_after_push", int'(count), 1);
    @(negedge clk);
    check("t2_start", int'(tx_start), 1);
    @(negedge clk);
    check("t2_start_width", int'(tx_start), 0);
    bcnt = 3;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
    end
    check("t2_busy_cycles", bcnt, 101);
    check("t2_count", int'(count), 0);
    check("t2_empty", int'(empty), 1);
    check("t2_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    // 3. burst of three
    pulse_t.delete();
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    wr_en = 1'b0;
    wait_idle("t3_idle", 600);
    check("t3_pulses", pulse_t.size(), 3);
    if (pulse_t.size() == 3) begin
      check("t3_spacing_1", pulse_t[1] - pulse_t[0], FRAME + 1);
      check("t3_spacing_2", pulse_t[2] - pulse_t[1], FRAME + 1);
    end
    check("t3_drained", sb.size(), 0);

    // 4. overflow
    pulse_t.delete();
    push(8'h10, 1'b1);
    push(8'h11, 1'b1);
    push(8'h12, 1'b1);
    push(8'h13, 1'b1);
    push(8'h14, 1'b1);
    push(8'h15, 1'b0);
    wr_en = 1'b0;
    check("t4_full", int'(full), 1);
    check("t4_count", int'(count), 4);
    check("t4_overflow", int'(overflow), 1);
    wait_idle("t4_idle", 1000);
    check("t4_overflow_sticky", int'(overflow), 1);
    check("t4_full_after", int'(full), 0);
    check("t4_pulses", pulse_t.size(), 5);
    check("t4_drained", sb.size(), 0);

    // 5. wrap with a push on every pop edge
    pulse_t.delete();
    push(8'h40, 1'b1);
    push(8'h41, 1'b1);
    wr_en = 1'b0;
    check("t5_first_pop", int'(tx_start), 1);
    check("t5_count_first", int'(count), 1);
    for (int k = 2; k < 9; k++) begin
      repeat (FRAME) @(negedge clk);
      cbefore = int'(count);
      push(8'h40 + 8'(k), 1'b1);
      wr_en = 1'b0;
      check("t5_pop_aligned", int'(tx_start), 1);
      check("t5_count_const", int'(count), cbefore);
    end
    wait_idle("t5_idle", 400);
    check("t5_pulses", pulse_t.size(), 9);
    check("t5_drained", sb.size(), 0);

    // 6. serial loopback, then reset during the second frame
    pulse_t.delete();
    push(8'h3C, 1'b1);
    push(8'h5A, 1'b1);
    wr_en = 1'b0;
    check("t6_first_start", int'(tx_start), 1);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 5 : 10) @(negedge clk);
      check($sformatf("t6_line_bit%0d", b), int'(line), exp_bits[b]);
    end
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_second_start", int'(tx_start), 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", int'(empty), 1);
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_tx_start", int'(tx_start), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_tx_data", int'(tx_data), 0);
    check("t6_rst_line", int'(line), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_start) seen++;
    end
    check("t6_no_restart", seen, 0);
    check("t6_line_idle", int'(line), 1);
    check("t6_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
